// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flags block.
//   DEF_DEPTH / DEF_WIDTH : default storage geometry
//   ptr_w()               : pointer width for a given depth
package sync_fifo_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 16;

  // Pointer width; a 1-word store still needs one address bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags.
//   master : producer/consumer side (drives flush, w_enb, din, r_enb)
//   slave  : FIFO side (drives dout, flags, count, error pulses)
interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CW = ptr_w(DEPTH) + 1;

  logic             flush;
  logic             w_enb;
  logic [WIDTH-1:0] din;
  logic             r_enb;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, w_enb, din, r_enb,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, w_enb, din, r_enb,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_flags: one synchronous write port, one
// asynchronous read port, no reset (contents are don't-care until written).
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, full/empty/almost flags and
// registered overflow/underflow pulses.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : sync_fifo_flags_if.slave (flush, w_enb, din, r_enb in;
//           dout, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out)
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through dout;
// otherwise dout is registered and updates the cycle after a read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic clk,
  input logic reset,
  sync_fifo_flags_if.slave bus
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 4");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 1 || AEMPTY_TH > DEPTH) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must be in 1..DEPTH");
  end

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, unf_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Flags come only from the registered count, so they are glitch-free and
  // snap to the reset values as soon as count_q clears.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // flush masks both ports; full/empty gating gives read-wins at full and
  // write-wins at empty for simultaneous requests.
  assign wr_acc = bus.w_enb && !full  && !bus.flush;
  assign rd_acc = bus.r_enb && !empty && !bus.flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth: natural wrap of AW-bit pointers is modulo DEPTH.
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= bus.w_enb && full  && !bus.flush;
      unf_q   <= bus.r_enb && empty && !bus.flush;
    end
  end

  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; forced to zero when empty so
  // stale storage never leaks out.
  assign bus.dout = empty ? '0 : mem_rdata;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
